// File: rtl/tt_transmision_param.sv
// -----------------------------------------------------------------------------
// tt_transmision_param
//   Automatic-transmission selector. It handles the P/N/R/D mode and the
//   NUM_GEARS forward gears in D. A brake interlock guards mode changes, and a
//   minimum-dwell counter paces the automatic up/down shifts. The block sits
//   between the driver selector/pedal inputs and the dashboard LED bank.
//
// Ports
//   clk        in   1          system clock, rising edge
//   reset      in   1          synchronous, active-high
//   sel_p/n/r/d in  1 each     mode requests; priority P > N > R > D
//   brake      in   1          brake pedal pressed
//   accel      in   1          accelerator pressed
//   mode       out  2          current mode (P=00, N=01, R=10, D=11)
//   gear       out  GW         current gear index, 0-based; 0 outside D
//   led_gear   out  NUM_GEARS  one-hot gear LED; all zero outside D
//   led_p/n/r  out  1 each     mode LEDs
//   shift_evt  out  1          1-cycle pulse after every gear change in D
//   reject     out  1          1-cycle pulse after a blocked mode request
// -----------------------------------------------------------------------------
module tt_transmision_param #(
   parameter  int NUM_GEARS    = 4,
   parameter  int DWELL_CYCLES = 8,
   localparam int GW           = $clog2(NUM_GEARS),
   localparam int CW           = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 sel_p,
   input  logic                 sel_n,
   input  logic                 sel_r,
   input  logic                 sel_d,
   input  logic                 brake,
   input  logic                 accel,
   output logic [1:0]           mode,
   output logic [GW-1:0]        gear,
   output logic [NUM_GEARS-1:0] led_gear,
   output logic                 led_p,
   output logic                 led_n,
   output logic                 led_r,
   output logic                 shift_evt,
   output logic                 reject
);

   typedef enum logic [1:0] {
      MODE_P = 2'b00,
      MODE_N = 2'b01,
      MODE_R = 2'b10,
      MODE_D = 2'b11
   } mode_e;

   localparam logic [CW-1:0] CNT_MAX  = CW'(DWELL_CYCLES - 1);
   localparam logic [GW-1:0] GEAR_MAX = GW'(NUM_GEARS - 1);

   mode_e          mode_q, mode_d;
   logic [GW-1:0]  gear_q, gear_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           shift_evt_q, shift_evt_d;
   logic           reject_q, reject_d;

   mode_e          req;
   logic           req_vld;
   logic           change_req;
   logic           blocked;

   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      mode_d      = mode_q;
      gear_d      = gear_q;
      cnt_d       = cnt_q;
      shift_evt_d = 1'b0;
      reject_d    = 1'b0;
      req         = MODE_P;
      req_vld     = 1'b1;

      if (sel_p)      req = MODE_P;
      else if (sel_n) req = MODE_N;
      else if (sel_r) req = MODE_R;
      else if (sel_d) req = MODE_D;
      else            req_vld = 1'b0;

      // A request for the current mode is a no-op and does not disturb shifting.
      change_req = req_vld && (req != mode_q);
      blocked    = ((mode_q == MODE_P) && !brake) ||
                   ((mode_q == MODE_D) && ((req == MODE_P) || (req == MODE_R)) &&
                    (gear_q != '0));

      if (change_req && !blocked) begin
         // Entering or leaving D always restarts from gear 0 with a fresh dwell.
         mode_d = req;
         gear_d = '0;
         cnt_d  = '0;
      end else begin
         reject_d = change_req;
         if (mode_q == MODE_D) begin
            if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + 1'b1;
            end else if (!reject_d) begin
               // A reject cycle holds the gear, which keeps reject and
               // shift_evt mutually exclusive. Brake wins over accel.
               if (brake && (gear_q != '0)) begin
                  gear_d      = gear_q - 1'b1;
                  cnt_d       = '0;
                  shift_evt_d = 1'b1;
               end else if (accel && !brake && (gear_q < GEAR_MAX)) begin
                  gear_d      = gear_q + 1'b1;
                  cnt_d       = '0;
                  shift_evt_d = 1'b1;
               end
            end
         end
      end
   end

   // NOTE: state flops use non-blocking assignments so every register samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         mode_q      <= MODE_P;
         gear_q      <= '0;
         cnt_q       <= '0;
         shift_evt_q <= 1'b0;
         reject_q    <= 1'b0;
      end else begin
         mode_q      <= mode_d;
         gear_q      <= gear_d;
         cnt_q       <= cnt_d;
         shift_evt_q <= shift_evt_d;
         reject_q    <= reject_d;
      end
   end

   assign mode      = mode_q;
   assign gear      = gear_q;
   assign led_gear  = (mode_q == MODE_D) ? (NUM_GEARS'(1) << gear_q) : '0;
   assign led_p     = (mode_q == MODE_P);
   assign led_n     = (mode_q == MODE_N);
   assign led_r     = (mode_q == MODE_R);
   assign shift_evt = shift_evt_q;
   assign reject    = reject_q;

endmodule
